// File: rtl/lif_pkg.sv
// Shared types and default constants for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  localparam int LIF_WIDTH         = 8;
  localparam int LIF_THRESHOLD     = 64;
  localparam int LIF_THRESHOLD_INC = 4;
  localparam int LIF_THRESHOLD_DEC = 2;
  localparam int LIF_THRESHOLD_MIN = 32;

  typedef logic [LIF_WIDTH-1:0] lif_state_t;

endpackage

// File: rtl/lif_core.sv
// Combinational single-neuron leak/integrate/fire and adaptive-threshold update.
// LIF_SCHED_REFRACTORY_EN: a neuron that spiked last update skips integration and cannot fire.
module lif_core #(
  parameter int WIDTH_P       = 8,
  parameter int THRESHOLD_INC = 4,
  parameter int THRESHOLD_DEC = 2,
  parameter int THRESHOLD_MIN = 32
) (
  input  logic [WIDTH_P-1:0] s_i,
  input  logic [WIDTH_P-1:0] t_i,
  input  logic               p_i,
  input  logic [WIDTH_P-1:0] c_i,
  output logic [WIDTH_P-1:0] s_nxt_o,
  output logic [WIDTH_P-1:0] t_nxt_o,
  output logic               spike_o
);

  logic [WIDTH_P:0] t_inc;
  assign t_inc = {1'b0, t_i} + (WIDTH_P+1)'(THRESHOLD_INC);

  always_comb begin
    s_nxt_o = (c_i != '0) ? (c_i + (s_i >> 1)) : (s_i - (s_i >> 3));
    spike_o = (s_i >= t_i);
    if (p_i) begin
      t_nxt_o = t_inc[WIDTH_P] ? '1 : t_inc[WIDTH_P-1:0];
    end else if (t_i > WIDTH_P'(THRESHOLD_MIN)) begin
      t_nxt_o = t_i - WIDTH_P'(THRESHOLD_DEC);
    end else begin
      t_nxt_o = t_i;
    end
`ifdef LIF_SCHED_REFRACTORY_EN
    if (p_i) begin
      spike_o = 1'b0;
      s_nxt_o = '0;
    end
`else
`endif
    if (spike_o) s_nxt_o = '0;
  end

endmodule

// File: rtl/lif_scheduler.sv
// Sweeps N_NEURONS LIF neurons through one shared lif_core per tick; N+1 cycles tick-to-done unstalled.
// A held spike event with evt_ready_i low stalls the sweep; LIF_SCHED_REFRACTORY_EN selects refractory mode.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS     = 4,
  parameter int WIDTH_P       = LIF_WIDTH,
  parameter int THRESHOLD     = LIF_THRESHOLD,
  parameter int THRESHOLD_INC = LIF_THRESHOLD_INC,
  parameter int THRESHOLD_DEC = LIF_THRESHOLD_DEC,
  parameter int THRESHOLD_MIN = LIF_THRESHOLD_MIN
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           tick_i,
  input  logic [N_NEURONS*WIDTH_P-1:0]   current_i,
  output logic                           evt_valid_o,
  input  logic                           evt_ready_i,
  output logic [$clog2(N_NEURONS)-1:0]   evt_id_o,
  output logic [N_NEURONS-1:0]           spike_vec_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           overrun_o
);

  localparam int IDW = $clog2(N_NEURONS);

  sched_state_t                         state_q, state_d;
  logic [IDW-1:0]                       idx_q;
  logic [N_NEURONS-1:0][WIDTH_P-1:0]    cur_q, st_q, thr_q;
  logic [N_NEURONS-1:0]                 spk_q;
  logic                                 evt_vld_q, busy_q, done_q, ovr_q;
  logic [IDW-1:0]                       evt_id_q;
  logic                                 advance, last, spike;
  logic [WIDTH_P-1:0]                   s_nxt, t_nxt;

  // The sweep only holds while an unaccepted event occupies the single event slot.
  assign advance = (state_q == SWEEP) && !(evt_vld_q && !evt_ready_i);
  assign last    = (idx_q == IDW'(N_NEURONS-1));

  lif_core #(
    .WIDTH_P      (WIDTH_P),
    .THRESHOLD_INC(THRESHOLD_INC),
    .THRESHOLD_DEC(THRESHOLD_DEC),
    .THRESHOLD_MIN(THRESHOLD_MIN)
  ) u_core (
    .s_i    (st_q[idx_q]),
    .t_i    (thr_q[idx_q]),
    .p_i    (spk_q[idx_q]),
    .c_i    (cur_q[idx_q]),
    .s_nxt_o(s_nxt),
    .t_nxt_o(t_nxt),
    .spike_o(spike)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick_i) state_d = SWEEP;
      SWEEP:   if (advance && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cur_q     <= '0;
      st_q      <= '0;
      thr_q     <= {N_NEURONS{WIDTH_P'(THRESHOLD)}};
      spk_q     <= '0;
      evt_vld_q <= 1'b0;
      evt_id_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (tick_i && (state_q != IDLE)) ovr_q <= 1'b1;
      if (tick_i && (state_q == IDLE)) begin
        cur_q <= current_i;
        idx_q <= '0;
      end
      if (advance) begin
        st_q[idx_q]  <= s_nxt;
        thr_q[idx_q] <= t_nxt;
        spk_q[idx_q] <= spike;
        idx_q        <= idx_q + 1'b1;
      end
      // A new spike may overwrite the slot in the same edge the previous event is accepted.
      if (advance && spike) begin
        evt_vld_q <= 1'b1;
        evt_id_q  <= idx_q;
      end else if (evt_ready_i) begin
        evt_vld_q <= 1'b0;
      end
    end
  end

  assign evt_valid_o = evt_vld_q;
  assign evt_id_o    = evt_id_q;
  assign spike_vec_o = spk_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign overrun_o   = ovr_q;

endmodule
